// File: rtl/bcd_scan_driver.sv
// Time-multiplexed 4-digit BCD scanner: guard cycle per digit, leading-zero blanking, frame-aligned display update.
// Outputs decode registered state only (no input-to-output path); no backpressure, a load is always accepted.
module bcd_scan_driver #(
  parameter int DWELL    = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_en_n,
  output logic        frame_done
);

  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   shd;
  logic          pend;

  logic          cnt_last;
  logic [3:0]    nib;
  logic [3:0]    lz;
  logic          blank;

  assign cnt_last   = (cnt == CNT_LAST);
  assign frame_done = cnt_last && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= 2'd0;
      disp <= 16'h0000;
      shd  <= 16'h0000;
      pend <= 1'b0;
    end else begin
      if (cnt_last) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // disp only ever changes on the frame boundary, so one frame never mixes two values
      if (frame_done) begin
        if (load) begin
          disp <= digits_in;
          shd  <= digits_in;
          pend <= 1'b0;
        end else if (pend) begin
          disp <= shd;
          pend <= 1'b0;
        end
      end else if (load) begin
        shd  <= digits_in;
        pend <= 1'b1;
      end
    end
  end

  always_comb begin
    nib        = disp[{idx, 2'b00} +: 4];
    lz         = 4'b0000;
    lz[3]      = (disp[15:12] == 4'd0);
    lz[2]      = lz[3] && (disp[11:8] == 4'd0);
    lz[1]      = lz[2] && (disp[7:4] == 4'd0);
    blank      = (BLANK_LZ != 0) && lz[idx];
    bcd_out    = 4'hF;
    digit_en_n = 4'b1111;
    // cnt==0 keeps every digit dark while the segment lines settle to the next digit
    if (cnt != '0) begin
      digit_en_n = ~(4'b0001 << idx);
      if ((nib <= 4'd9) && !blank)
        bcd_out = nib;
    end
  end

endmodule
